uart_rx: RTL



---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a frame-error/break guard.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra o_ParityErr output.
module uart_rx #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_RxSerial,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_FrameErr,
`ifdef UART_RX_PARITY_EN
  output logic       o_ParityErr,
`endif
  output logic       o_Busy
);

  localparam int BIT_MAX =
    ((SYS_CLOCK * 10 / UART_BAUDRATE + 5) / 10) - 1;
  localparam int HALF = BIT_MAX / 2;
  localparam int CW   = $clog2(BIT_MAX) + 1;

  localparam logic [CW-1:0] BIT_MAX_C = CW'(BIT_MAX);
  localparam logic [CW-1:0] HALF_C    = CW'(HALF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  logic cnt_wrap;
  assign cnt_wrap = (cnt == BIT_MAX_C);

  // Two-flop synchroniser; idle-high so reset never looks like a start bit
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RxSerial;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: start check at half bit, then sample every full bit
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      o_RxByte   <= '0;
      o_RxValid  <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      o_ParityErr <= 1'b0;
`endif
    end else begin
      o_RxValid  <= 1'b0;
      o_FrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_ParityErr <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            o_Busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_wrap) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_wrap) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_wrap) begin
            cnt <= '0;
            if (rx_s) begin
              o_RxByte  <= shift;
              o_RxValid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_ParityErr <= ^{shift, par_bit};
`endif
              state  <= IDLE;
              o_Busy <= 1'b0;
            end else begin
              o_FrameErr <= 1'b1;
              state      <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
